// File: rtl/dma_host_endpoint.sv
// dma_host_endpoint
//   Host-memory-side responder for the DMA data-mover interface. It accepts a
//   transfer request, acknowledges it for one cycle, then sinks write beats
//   into, or sources read beats from, a DEPTH x 128-bit local memory. The same
//   memory is reachable through a backdoor port (write only while idle, read
//   every cycle with one cycle of latency).
//
//   Optional feature: define DMA_HOST_BOUNDS_CHECK_EN to reject requests whose
//   addr+len runs past the end of memory (dma_err with dma_resp, no data
//   phase). When it is undefined, addresses wrap and dma_err stays 0.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   dma_req/rwn/addr/len       request; sampled only in IDLE
//   dma_resp, dma_err          one-cycle acknowledge and its error flag
//   dma_write_valid/data/ready write beat channel (endpoint sinks)
//   dma_read_valid/data/ready  read beat channel (endpoint sources)
//   xfer_done                  one-cycle pulse after the final beat
//   busy                       high whenever the FSM is not IDLE
//   host_wr_en/addr/wdata      backdoor write (honoured only in IDLE)
//   host_rdata                 backdoor read data, 1-cycle latency
module dma_host_endpoint #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_req,
  input  logic              dma_rwn,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [LEN_W-1:0]  dma_len,
  output logic              dma_resp,
  output logic              dma_err,
  input  logic              dma_write_valid,
  input  logic [127:0]      dma_write_data,
  output logic              dma_write_ready,
  output logic              dma_read_valid,
  output logic [127:0]      dma_read_data,
  input  logic              dma_read_ready,
  output logic              xfer_done,
  output logic              busy,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [127:0]      host_wdata,
  output logic [127:0]      host_rdata
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_RESP, S_WRITE, S_READ, S_DONE} state_t;

  state_t            state, state_nxt;
  logic              rwn_q;
  logic              err_q;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  remaining;
  logic [127:0]      mem [DEPTH];

  logic              wr_hs, rd_hs, last_beat, req_err;
  logic              resp_d, err_d, wready_d, rvalid_d, done_d, busy_d;
  logic              mem_we, rd_load;
  logic [ADDR_W-1:0] mem_waddr, rd_addr;
  logic [127:0]      mem_wdata;

  // Handshakes qualify on the registered valid/ready, which mirror the state.
  assign wr_hs     = dma_write_ready && dma_write_valid;
  assign rd_hs     = dma_read_valid && dma_read_ready;
  assign last_beat = (remaining == LEN_W'(1));

`ifdef DMA_HOST_BOUNDS_CHECK_EN
  logic [ADDR_W+LEN_W:0] end_addr;
  assign end_addr = {{(LEN_W+1){1'b0}}, dma_addr} + {{(ADDR_W+1){1'b0}}, dma_len};
  assign req_err  = (end_addr > (ADDR_W+LEN_W+1)'(DEPTH));
`else
  assign req_err  = 1'b0;
`endif

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (dma_req) state_nxt = S_RESP;
      S_RESP: begin
        if (err_q || remaining == '0) state_nxt = S_DONE;
        else if (rwn_q)               state_nxt = S_READ;
        else                          state_nxt = S_WRITE;
      end
      S_WRITE: if (wr_hs && last_beat) state_nxt = S_DONE;
      S_READ:  if (rd_hs && last_beat) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  // Outputs are registered, so decode them from the state being entered.
  always_comb begin
    resp_d   = (state_nxt == S_RESP);
    err_d    = (state_nxt == S_RESP) && ((state == S_IDLE) ? req_err : err_q);
    wready_d = (state_nxt == S_WRITE);
    rvalid_d = (state_nxt == S_READ);
    done_d   = (state_nxt == S_DONE);
    busy_d   = (state_nxt != S_IDLE);
  end

  // Read data loads mem[ptr] in RESP, then the following word on each
  // handshake so beats stream without bubbles; otherwise it holds.
  assign rd_load = (state == S_RESP) || rd_hs;
  assign rd_addr = (state == S_RESP) ? ptr : ptr + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      dma_resp        <= 1'b0;
      dma_err         <= 1'b0;
      dma_write_ready <= 1'b0;
      dma_read_valid  <= 1'b0;
      dma_read_data   <= '0;
      xfer_done       <= 1'b0;
      busy            <= 1'b0;
      host_rdata      <= '0;
    end else begin
      dma_resp        <= resp_d;
      dma_err         <= err_d;
      dma_write_ready <= wready_d;
      dma_read_valid  <= rvalid_d;
      xfer_done       <= done_d;
      busy            <= busy_d;
      host_rdata      <= mem[host_addr];
      if (rd_load) dma_read_data <= mem[rd_addr];
    end
  end

  // ---------------- pointer / count ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rwn_q     <= 1'b0;
      err_q     <= 1'b0;
      ptr       <= '0;
      remaining <= '0;
    end else begin
      if (state == S_IDLE && dma_req) begin
        rwn_q     <= dma_rwn;
        err_q     <= req_err;
        ptr       <= dma_addr;
        remaining <= dma_len;
      end else if ((state == S_WRITE && wr_hs) || (state == S_READ && rd_hs)) begin
        // ADDR_W-bit increment wraps modulo DEPTH; handshakes only happen
        // with remaining >= 1, so the count cannot underflow.
        ptr       <= ptr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  // ---------------- memory ----------------
  // Single write port: DMA beats during WRITE, backdoor only in IDLE, so the
  // two sources never coincide. Contents survive reset.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = host_addr;
    mem_wdata = host_wdata;
    if (!rst) begin
      if (state == S_WRITE && wr_hs) begin
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdata = dma_write_data;
      end else if (state == S_IDLE && host_wr_en) begin
        mem_we    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_dma_host_endpoint.sv
module tb_dma_host_endpoint;

  logic         clk = 1'b0;
  logic         rst;
  logic         dma_req, dma_rwn;
  logic [9:0]   dma_addr;
  logic [15:0]  dma_len;
  logic         dma_resp, dma_err;
  logic         dma_write_valid;
  logic [127:0] dma_write_data;
  logic         dma_write_ready;
  logic         dma_read_valid;
  logic [127:0] dma_read_data;
  logic         dma_read_ready;
  logic         xfer_done, busy;
  logic         host_wr_en;
  logic [9:0]   host_addr;
  logic [127:0] host_wdata, host_rdata;

  int checks = 0;
  int errors = 0;

  dma_host_endpoint #(.ADDR_W(10), .LEN_W(16)) dut (
    .clk(clk), .rst(rst),
    .dma_req(dma_req), .dma_rwn(dma_rwn), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_resp(dma_resp), .dma_err(dma_err),
    .dma_write_valid(dma_write_valid), .dma_write_data(dma_write_data),
    .dma_write_ready(dma_write_ready),
    .dma_read_valid(dma_read_valid), .dma_read_data(dma_read_data),
    .dma_read_ready(dma_read_ready),
    .xfer_done(xfer_done), .busy(busy),
    .host_wr_en(host_wr_en), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic bd_write(input logic [9:0] a, input logic [127:0] d);
    host_wr_en = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_wr_en = 1'b0;
  endtask

  task automatic bd_read(input logic [9:0] a, output logic [127:0] d);
    host_addr = a;
    tick();
    d = host_rdata;
  endtask

  task automatic request(input logic rwn, input logic [9:0] a, input logic [15:0] l);
    dma_req = 1'b1; dma_rwn = rwn; dma_addr = a; dma_len = l;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    checks++; if ({dma_resp, dma_err, dma_write_ready, dma_read_valid, xfer_done, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000000", {dma_resp, dma_err, dma_write_ready, dma_read_valid, xfer_done, busy}); end
    checks++; if (dma_read_data !== 128'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", dma_read_data); end
    checks++; if (host_rdata !== 128'h0) begin errors++; $display("FAIL reset_host_rdata got %h exp 0", host_rdata); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_burst;
    logic [127:0] d;
    bd_write(10'h014, 128'h55);              // guard word just past the burst
    request(1'b0, 10'h010, 16'd4);
    tick();
    dma_req = 1'b0;
    checks++; if (dma_resp !== 1'b1 || dma_err !== 1'b0) begin errors++; $display("FAIL wr_resp got resp=%b err=%b exp 1 0", dma_resp, dma_err); end
    checks++; if (dma_write_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wr_resp_ready got rdy=%b busy=%b exp 0 1", dma_write_ready, busy); end
    dma_write_valid = 1'b1; dma_write_data = 128'hA0;
    tick();
    checks++; if (dma_resp !== 1'b0) begin errors++; $display("FAIL wr_resp_pulse got %b exp 0", dma_resp); end
    for (int i = 0; i < 4; i++) begin
      dma_write_data = 128'hA0 + 128'(i);
      checks++; if (dma_write_ready !== 1'b1) begin errors++; $display("FAIL wr_ready beat %0d got %b exp 1", i, dma_write_ready); end
      tick();
    end
    // valid stays high into DONE: no fifth beat may land at 0x014
    dma_write_data = 128'hFF;
    checks++; if (dma_write_ready !== 1'b0 || xfer_done !== 1'b1) begin errors++; $display("FAIL wr_done got rdy=%b done=%b exp 0 1", dma_write_ready, xfer_done); end
    tick();
    dma_write_valid = 1'b0;
    checks++; if (xfer_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_idle got done=%b busy=%b exp 0 0", xfer_done, busy); end
    for (int i = 0; i < 4; i++) begin
      bd_read(10'h010 + 10'(i), d);
      checks++; if (d !== 128'hA0 + 128'(i)) begin errors++; $display("FAIL wr_mem[%0d] got %h exp %h", i, d, 128'hA0 + 128'(i)); end
    end
    bd_read(10'h014, d);
    checks++; if (d !== 128'h55) begin errors++; $display("FAIL wr_no_extra_beat got %h exp 55", d); end
  endtask

  task automatic test_read_backpressure;
    logic [127:0] exp_d [3];
    logic         rdy [5];
    int           idx;
    exp_d[0] = 128'hB0; exp_d[1] = 128'hB1; exp_d[2] = 128'hB2;
    rdy[0] = 1; rdy[1] = 0; rdy[2] = 0; rdy[3] = 1; rdy[4] = 1;
    for (int i = 0; i < 3; i++) bd_write(10'h020 + 10'(i), exp_d[i]);
    request(1'b1, 10'h020, 16'd3);
    tick();
    dma_req = 1'b0;
    checks++; if (dma_resp !== 1'b1 || dma_read_valid !== 1'b0) begin errors++; $display("FAIL rd_resp got resp=%b vld=%b exp 1 0", dma_resp, dma_read_valid); end
    tick();
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      dma_read_ready = rdy[c];
      checks++; if (dma_read_valid !== 1'b1 || dma_read_data !== exp_d[idx]) begin
        errors++; $display("FAIL rd_beat cyc %0d got vld=%b data=%h exp 1 %h", c, dma_read_valid, dma_read_data, exp_d[idx]); end
      tick();
      if (rdy[c]) idx++;
    end
    dma_read_ready = 1'b0;
    checks++; if (dma_read_valid !== 1'b0 || xfer_done !== 1'b1) begin errors++; $display("FAIL rd_done got vld=%b done=%b exp 0 1", dma_read_valid, xfer_done); end
    tick();
  endtask

  task automatic test_zero_len;
    dma_write_valid = 1'b1; dma_write_data = 128'h77;
    request(1'b0, 10'h040, 16'd0);
    tick();
    dma_req = 1'b0;
    checks++; if (dma_resp !== 1'b1) begin errors++; $display("FAIL zl_resp got %b exp 1", dma_resp); end
    tick();
    checks++; if ({dma_resp, dma_write_ready, dma_read_valid, xfer_done} !== 4'b0001) begin
      errors++; $display("FAIL zl_done got resp/rdy/vld/done=%b exp 0001", {dma_resp, dma_write_ready, dma_read_valid, xfer_done}); end
    dma_write_valid = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || xfer_done !== 1'b0) begin errors++; $display("FAIL zl_idle got busy=%b done=%b exp 0 0", busy, xfer_done); end
  endtask

  task automatic test_wrap;
    logic [127:0] d;
    logic [9:0]   a [4];
    a[0] = 10'h3FE; a[1] = 10'h3FF; a[2] = 10'h000; a[3] = 10'h001;
    for (int i = 0; i < 4; i++) bd_write(a[i], 128'hEE);
    request(1'b0, 10'h3FE, 16'd4);
    tick();
    dma_req = 1'b0;
`ifdef DMA_HOST_BOUNDS_CHECK_EN
    checks++; if (dma_resp !== 1'b1 || dma_err !== 1'b1) begin errors++; $display("FAIL bnd_err got resp=%b err=%b exp 1 1", dma_resp, dma_err); end
    dma_write_valid = 1'b1; dma_write_data = 128'h1;
    tick();
    checks++; if (dma_write_ready !== 1'b0 || xfer_done !== 1'b1) begin errors++; $display("FAIL bnd_done got rdy=%b done=%b exp 0 1", dma_write_ready, xfer_done); end
    dma_write_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      bd_read(a[i], d);
      checks++; if (d !== 128'hEE) begin errors++; $display("FAIL bnd_mem[%h] got %h exp ee", a[i], d); end
    end
`else
    checks++; if (dma_resp !== 1'b1 || dma_err !== 1'b0) begin errors++; $display("FAIL wrap_resp got resp=%b err=%b exp 1 0", dma_resp, dma_err); end
    dma_write_valid = 1'b1; dma_write_data = 128'h1;
    tick();
    for (int i = 0; i < 4; i++) begin
      dma_write_data = 128'(i + 1);
      tick();
    end
    dma_write_valid = 1'b0;
    checks++; if (xfer_done !== 1'b1) begin errors++; $display("FAIL wrap_done got %b exp 1", xfer_done); end
    tick();
    for (int i = 0; i < 4; i++) begin
      bd_read(a[i], d);
      checks++; if (d !== 128'(i + 1)) begin errors++; $display("FAIL wrap_mem[%h] got %h exp %0d", a[i], d, i + 1); end
    end
`endif
  endtask

  task automatic test_busy;
    logic [127:0] d;
    request(1'b0, 10'h010, 16'd4);
    tick();
    dma_req = 1'b0;
    dma_write_valid = 1'b1; dma_write_data = 128'hC0;
    tick();
    for (int i = 0; i < 4; i++) begin
      dma_write_data = 128'hC0 + 128'(i);
      if (i < 3) begin
        request(1'b1, 10'h100, 16'd1);
        host_wr_en = 1'b1; host_addr = 10'h011; host_wdata = 128'hDEAD;
      end else begin
        dma_req = 1'b0; host_wr_en = 1'b0;
      end
      checks++; if (busy !== 1'b1 || dma_resp !== 1'b0) begin errors++; $display("FAIL busy_beat %0d got busy=%b resp=%b exp 1 0", i, busy, dma_resp); end
      tick();
    end
    dma_write_valid = 1'b0;
    checks++; if (busy !== 1'b1 || xfer_done !== 1'b1) begin errors++; $display("FAIL busy_done got busy=%b done=%b exp 1 1", busy, xfer_done); end
    tick();
    tick();
    checks++; if (dma_resp !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL busy_req_ignored got resp=%b busy=%b exp 0 0", dma_resp, busy); end
    bd_read(10'h011, d);
    checks++; if (d !== 128'hC1) begin errors++; $display("FAIL busy_bd_dropped got %h exp c1", d); end
  endtask

  task automatic test_reset_mid_read;
    for (int i = 0; i < 4; i++) bd_write(10'h030 + 10'(i), 128'hD0 + 128'(i));
    request(1'b1, 10'h030, 16'd4);
    tick();
    dma_req = 1'b0;
    tick();
    dma_read_ready = 1'b1;
    tick();
    checks++; if (dma_read_valid !== 1'b1 || dma_read_data !== 128'hD1) begin errors++; $display("FAIL rst_pre got vld=%b data=%h exp 1 d1", dma_read_valid, dma_read_data); end
    rst = 1'b1; dma_read_ready = 1'b0;
    tick();
    rst = 1'b0;
    checks++; if ({dma_resp, dma_err, dma_write_ready, dma_read_valid, xfer_done, busy} !== 6'b0 || dma_read_data !== 128'h0 || host_rdata !== 128'h0) begin
      errors++; $display("FAIL rst_mid got ctrl=%b rdata=%h hrdata=%h exp 0", {dma_resp, dma_err, dma_write_ready, dma_read_valid, xfer_done, busy}, dma_read_data, host_rdata); end
    tick();
    checks++; if (xfer_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_no_done got done=%b busy=%b exp 0 0", xfer_done, busy); end
    request(1'b1, 10'h032, 16'd1);
    tick();
    dma_req = 1'b0;
    checks++; if (dma_resp !== 1'b1) begin errors++; $display("FAIL rst_new_resp got %b exp 1", dma_resp); end
    tick();
    dma_read_ready = 1'b1;
    checks++; if (dma_read_valid !== 1'b1 || dma_read_data !== 128'hD2) begin errors++; $display("FAIL rst_new_beat got vld=%b data=%h exp 1 d2", dma_read_valid, dma_read_data); end
    tick();
    dma_read_ready = 1'b0;
    checks++; if (dma_read_valid !== 1'b0 || xfer_done !== 1'b1) begin errors++; $display("FAIL rst_new_done got vld=%b done=%b exp 0 1", dma_read_valid, xfer_done); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    dma_req = 1'b0; dma_rwn = 1'b0; dma_addr = '0; dma_len = '0;
    dma_write_valid = 1'b0; dma_write_data = '0; dma_read_ready = 1'b0;
    host_wr_en = 1'b0; host_addr = '0; host_wdata = '0;
    test_reset();
    test_write_burst();
    test_read_backpressure();
    test_zero_len();
    test_wrap();
    test_busy();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_host_endpoint.md
Name: dma_host_endpoint

Overview:
Host-memory-side responder for the DMA engine's data-mover interface. It accepts a transfer request, acknowledges it, and then either sinks write beats into local memory or sources read beats from it. The memory is DEPTH 128-bit words and is also reachable through a backdoor port. The block sits on the host-bridge side and stands in for host memory in subsystem simulation and FPGA bring-up.

Parameters:
ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W 128-bit words
LEN_W, 16, width of transfer length in beats

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
dma_req  in  1  transfer request, sampled only in IDLE
dma_rwn  in  1  1 = read (endpoint sources data), 0 = write (endpoint sinks data)
dma_addr  in  ADDR_W  start word address, sampled with dma_req
dma_len  in  LEN_W  beat count, sampled with dma_req
dma_resp  out  1  one-cycle request acknowledge
dma_err  out  1  error flag, valid with dma_resp
dma_write_valid  in  1  write beat valid
dma_write_data  in  128  write beat data
dma_write_ready  out  1  endpoint accepts write beat
dma_read_valid  out  1  read beat valid
dma_read_data  out  128  read beat data
dma_read_ready  in  1  requester accepts read beat
xfer_done  out  1  one-cycle pulse after the final beat
busy  out  1  high whenever state != IDLE
host_wr_en  in  1  backdoor write strobe
host_addr  in  ADDR_W  backdoor address
host_wdata  in  128  backdoor write data
host_rdata  out  128  backdoor read data, 1-cycle latency

Behaviour:
- All outputs are registered. Reset (sync, active-high) drives every output to 0, sets state to IDLE, and clears pointer and count registers. Memory contents are not cleared.
- Reset mid-transfer: the transfer is abandoned next edge with no xfer_done. Memory writes already done stay.
- States are IDLE, RESP, WRITE, READ, DONE.
- IDLE:
  - dma_req=1 latches rwn, addr into ptr, and len into remaining; goes to RESP.
  - dma_req in any other state is ignored.
- RESP: dma_resp=1 for exactly this one cycle.
  - remaining==0: go to DONE.
  - rwn=0: go to WRITE.
  - rwn=1: go to READ and load dma_read_data <= mem[ptr].
- WRITE:
  - dma_write_ready=1.
  - Each cycle with valid&&ready: mem[ptr] <= data, ptr++, remaining--.
  - When the last beat is accepted, ready drops the next cycle and the state goes to DONE. No extra beat is accepted.
- READ:
  - dma_read_valid=1 starting the cycle after RESP. Data stays stable while valid=1 and ready=0.
  - On valid&&ready: ptr++, remaining--, and the next word loads the same edge, so there are no bubbles and back-to-back beats run at 1 per cycle.
  - When the last beat handshakes, valid drops the next cycle and the state goes to DONE.
- DONE: xfer_done=1 for one cycle, then IDLE. Request-to-request minimum spacing is 3 + len cycles.
- Address arithmetic: ptr wraps modulo DEPTH (ADDR_W-bit increment). remaining is LEN_W bits and never underflows.
- Backdoor:
  - host_rdata <= mem[host_addr] every cycle.
  - host_wr_en is honoured only in IDLE and silently dropped otherwise.
  - Backdoor write and RESP read load cannot collide because RESP is not IDLE.
- dma_err is 0 in all cases without the optional feature.

Optional Feature:
Macro DMA_HOST_BOUNDS_CHECK_EN.
- Defined:
  - In IDLE, when dma_req=1 and dma_addr + dma_len > DEPTH (computed ADDR_W+LEN_W+1 wide), RESP asserts dma_resp=1 and dma_err=1 together.
  - No data phase follows: state goes directly to DONE, and xfer_done still pulses.
  - Memory is untouched.
- Undefined: no check; addresses wrap and dma_err is tied 0.

Test Plan:
- Write burst: req rwn=0 addr=0x010 len=4, data 0xA0..0xA3 with valid held high → dma_resp 1 cycle after req, ready high 4 beats, xfer_done pulse; backdoor reads 0x010..0x013 = 0xA0..0xA3.
- Read burst with backpressure: backdoor preload 0x020..0x022 = 0xB0..0xB2; req rwn=1 addr=0x020 len=3, ready toggling 1,0,0,1,1 → beats 0xB0,0xB1,0xB2 in order, data stable during stalls, valid low after the 3rd handshake.
- Zero length: req len=0 → dma_resp pulse, no ready/valid activity, xfer_done 2 cycles after req.
- Wrap: ADDR_W=10, write addr=0x3FE len=4, data 1..4 → mem[0x3FE]=1, [0x3FF]=2, [0x000]=3, [0x001]=4; with DMA_HOST_BOUNDS_CHECK_EN instead dma_err=1 with dma_resp and memory unchanged.
- Busy interactions: a second dma_req and a host_wr_en to 0x011 issued during WRITE → both ignored; mem[0x011] holds the burst value; busy high throughout.
- Reset mid-read after 1 of 4 beats → next cycle all outputs 0, state IDLE, no xfer_done; new req served normally.
